// File: rtl/hw_qsys_cpu_mul_combine.sv
// hw_qsys_cpu_mul_combine
// Final stage of the CPU multiply cell. It combines three 16x16 partial
// products into the low 32 bits of the 32x32 product. Results are queued in
// a small in-order FIFO and handed to writeback with a valid/ready handshake.
// mul_busy stops new issues while the FIFO plus the in-flight work could
// fill it.
// Optional build macro MUL_STATS_EN: adds the stat_mul_count and
// stat_stall_count counters and their output ports.
module hw_qsys_cpu_mul_combine #(
    parameter int FIFO_DEPTH = 2,
    parameter int ADD_PIPE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_issue,
    input  logic        M_en,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    output logic        mul_busy,
    output logic [31:0] W_mul_result,
    output logic        W_mul_valid,
    input  logic        W_mul_ready
`ifdef MUL_STATS_EN
    ,
    output logic [31:0] stat_mul_count,
    output logic [31:0] stat_stall_count
`endif
);

    // STAGES is the index of the vld_pipe bit that carries a FIFO write
    localparam int STAGES = (ADD_PIPE != 0) ? 1 : 0;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int PW     = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    logic [STAGES:0]                vld_pipe;
    logic                           accept;
    logic                           wr_en;
    logic                           rd_en;
    logic [CW-1:0]                  count;
    logic [CW-1:0]                  in_flight;
    logic [CW:0]                    occ;
    logic [PW-1:0]                  wr_ptr;
    logic [PW-1:0]                  rd_ptr;
    logic [FIFO_DEPTH-1:0][31:0]    mem;
    logic [31:0]                    last_q;
    logic [15:0]                    a_mid;
    logic [31:0]                    b_p1;
    logic [15:0]                    b_mid;
    logic [31:0]                    sum;
    logic                           unused_hi;

    // Only the low halves of the cross products land in the low 32 bits
    assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

    assign occ      = {1'b0, count} + {1'b0, in_flight};
    assign mul_busy = (occ >= (CW+1)'(FIFO_DEPTH));
    assign accept   = mul_issue & M_en & ~mul_busy;
    assign wr_en    = vld_pipe[STAGES];
    assign rd_en    = W_mul_valid & W_mul_ready;

    // Stage A: the carry out of the 16-bit mid sum falls above bit 31, so it is dropped
    assign a_mid = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];

    generate
        if (ADD_PIPE != 0) begin : g_add_pipe
            // Register stage A; the cell holds the partials only for the cycle after accept
            always_ff @(posedge clk) begin
                if (vld_pipe[0]) begin
                    b_p1  <= M_mul_cell_p1;
                    b_mid <= a_mid;
                end
            end
        end else begin : g_add_comb
            assign b_p1  = M_mul_cell_p1;
            assign b_mid = a_mid;
        end
    endgenerate

    // Stage B: final sum, wrapping at 32 bits
    assign sum = b_p1 + {b_mid, 16'h0000};

    assign W_mul_valid  = (count != '0);
    assign W_mul_result = W_mul_valid ? mem[rd_ptr] : last_q;

    // Valid bits walk down the add pipe; reset drops all work in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i <= STAGES; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Count of issues accepted but not yet written to the FIFO
    always_ff @(posedge clk) begin
        if (reset)
            in_flight <= '0;
        else if (accept && !wr_en)
            in_flight <= in_flight + 1'b1;
        else if (!accept && wr_en)
            in_flight <= in_flight - 1'b1;
    end

    // FIFO storage and pointers; pointers wrap at FIFO_DEPTH, not at a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= sum;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (!wr_en && rd_en)
                count <= count - 1'b1;
        end
    end

    // Keep the last popped value on the output while the FIFO is empty
    always_ff @(posedge clk) begin
        if (reset)
            last_q <= '0;
        else if (rd_en)
            last_q <= mem[rd_ptr];
    end

`ifdef MUL_STATS_EN
    // Count pops and issue attempts blocked by busy; both wrap at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_mul_count   <= '0;
            stat_stall_count <= '0;
        end else begin
            if (rd_en)
                stat_mul_count <= stat_mul_count + 32'd1;
            if (mul_issue && M_en && mul_busy)
                stat_stall_count <= stat_stall_count + 32'd1;
        end
    end
`endif

endmodule
